// File: rtl/data_mem_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_pkg
// Shared definitions for the data-memory responder:
//   - state_e    : responder FSM state encoding (IDLE / WAIT / RESP)
//   - BYTE_W     : width of one byte lane
//   - WORD_BYTES : byte lanes per 32-bit word
//   - addr_fault : flags a byte address that is misaligned or outside storage
// -----------------------------------------------------------------------------
package data_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int unsigned BYTE_W     = 8;
   localparam int unsigned WORD_BYTES = 4;

   // A request faults when it is not word aligned, or when any address bit
   // above the word index is set. There is deliberately no wrap-around.
   function automatic logic addr_fault(input logic [31:0] addr,
                                       input int unsigned addr_width);
      logic misaligned;
      logic out_of_range;
      misaligned   = (addr[1:0] != 2'b00);
      out_of_range = ((addr >> (addr_width + 2)) != 32'd0);
      return misaligned | out_of_range;
   endfunction

endpackage

// File: rtl/data_mem_array.sv
// -----------------------------------------------------------------------------
// data_mem_array
// Synchronous single-port word RAM, 2**ADDR_WIDTH x 32 bits, with per-byte
// write enables and a registered read port.
//   clk      : clock
//   en_i     : access enable for this cycle
//   we_i     : 1 = write the enabled bytes, 0 = read the full word
//   addr_i   : word index
//   be_i     : byte enables for writes (ignored for reads)
//   wdata_i  : write data
//   rdata_o  : read data, updated on the edge of an enabled read
// -----------------------------------------------------------------------------
module data_mem_array
   import data_mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  en_i,
   input  logic                  we_i,
   input  logic [ADDR_WIDTH-1:0] addr_i,
   input  logic [3:0]            be_i,
   input  logic [31:0]           wdata_i,
   output logic [31:0]           rdata_o
);

   logic [31:0] mem_q [2**ADDR_WIDTH];
   logic [31:0] rdata_q;

   // NOTE: storage and its read register have no reset; contents must survive
   // a reset of the responder, and a reset branch would stop RAM inference.
   always_ff @(posedge clk) begin
      if (en_i) begin
         if (we_i) begin
            for (int b = 0; b < WORD_BYTES; b++) begin
               if (be_i[b]) begin
                  mem_q[addr_i][b*BYTE_W +: BYTE_W] <= wdata_i[b*BYTE_W +: BYTE_W];
               end
            end
         end else begin
            rdata_q <= mem_q[addr_i];
         end
      end
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// -----------------------------------------------------------------------------
// data_mem_responder
// Responder end of the CPU data-memory interface. Accepts one request at a
// time on a valid/ready handshake, waits LATENCY cycles, commits the access to
// the word RAM and returns a single-cycle response.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req_valid   : request present          req_ready  : responder idle
//   req_write   : 1 = store, 0 = load      req_addr   : byte address
//   req_wdata   : store data               req_be     : store byte enables
//   resp_valid  : one-cycle response       resp_rdata : load data (else 0)
//   resp_err    : misaligned/out-of-range  busy       : request in flight
// -----------------------------------------------------------------------------
module data_mem_responder
   import data_mem_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned LATENCY    = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [3:0]  req_be,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam logic [3:0] CNT_INIT = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

   state_e                state_q;
   logic [3:0]            cnt_q;
   logic [ADDR_WIDTH-1:0] idx_q;
   logic [31:0]           wdata_q;
   logic [3:0]            be_q;
   logic                  write_q;
   logic                  err_q;

   logic                  in_idle;
   logic                  accept;
   logic                  req_fault;
   logic                  commit;
   logic                  c_write;
   logic                  c_err;
   logic [ADDR_WIDTH-1:0] c_idx;
   logic [31:0]           c_wdata;
   logic [3:0]            c_be;
   logic [31:0]           ram_rdata;

   assign in_idle   = (state_q == IDLE);
   assign accept    = req_valid & in_idle;
   assign req_fault = addr_fault(req_addr, ADDR_WIDTH);

   // Commit happens on the edge entering RESP. With zero wait states that is
   // the accept edge itself, so the RAM must see the live request fields
   // rather than the captured copies.
   assign commit  = (LATENCY == 0) ? accept : ((state_q == WAIT) && (cnt_q == 4'd0));
   assign c_write = in_idle ? req_write                    : write_q;
   assign c_err   = in_idle ? req_fault                    : err_q;
   assign c_idx   = in_idle ? req_addr[ADDR_WIDTH+1:2]     : idx_q;
   assign c_wdata = in_idle ? req_wdata                    : wdata_q;
   assign c_be    = in_idle ? req_be                       : be_q;

   data_mem_array #(
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_array (
      .clk     (clk),
      .en_i    (commit & ~c_err),
      .we_i    (c_write),
      .addr_i  (c_idx),
      .be_i    (c_be),
      .wdata_i (c_wdata),
      .rdata_o (ram_rdata)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         wdata_q <= 32'd0;
         be_q    <= 4'd0;
         write_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  idx_q   <= req_addr[ADDR_WIDTH+1:2];
                  wdata_q <= req_wdata;
                  be_q    <= req_be;
                  write_q <= req_write;
                  err_q   <= req_fault;
                  if (LATENCY == 0) begin
                     state_q <= RESP;
                  end else begin
                     state_q <= WAIT;
                     cnt_q   <= CNT_INIT;
                  end
               end
            end
            WAIT: begin
               if (cnt_q == 4'd0) begin
                  state_q <= RESP;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
               end
            end
            RESP:    state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

   // Response data is forced to zero outside RESP and for stores/faults, so
   // stale RAM read data never leaks onto the bus.
   assign req_ready  = in_idle;
   assign busy       = ~in_idle;
   assign resp_valid = (state_q == RESP);
   assign resp_err   = resp_valid & err_q;
   assign resp_rdata = (resp_valid & ~write_q & ~err_q) ? ram_rdata : 32'd0;

endmodule
